// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word width, RAM handshake states and arbiter FSM states.
package cpu_types_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned TIMER_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        DACC,
        IACC,
        DRESP,
        IRESP
    } arb_state_t;

endpackage

// File: rtl/access_timer.sv
// Per-access watchdog: counts cycles while enabled, saturating at the limit.
import cpu_types_pkg::*;

module access_timer (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] limit,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != limit)) begin
            count <= count + 1'b1;
        end
    end

    // Looks one edge ahead so the access is dropped on the very edge the count reaches the limit.
    assign expired = ({1'b0, count} + 9'd1) >= {1'b0, limit};

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data accesses; data has priority.
import cpu_types_pkg::*;

module memory_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dmemREN,
    input  logic      dmemWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output logic      dhit,
    output word_t     iload,
    output word_t     dload,
    output logic      merr,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    arb_state_t state;
    word_t      addrQ;
    word_t      storeQ;
    logic       writeQ;
    logic       conflictQ;
    logic       timerClear;
    logic       timerEnable;
    logic       timerExpired;
    logic       accessDone;

    assign timerClear  = (state == IDLE);
    assign timerEnable = (state == DACC) || (state == IACC);
    assign accessDone  = (ramstate == ACCESS) || (ramstate == ERROR) || timerExpired;

    access_timer uTimer (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (timerClear),
        .enable  (timerEnable),
        .limit   (TIMEOUT),
        .expired (timerExpired)
    );

    assign ramaddr  = addrQ;
    assign ramstore = storeQ;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            addrQ     <= '0;
            storeQ    <= '0;
            writeQ    <= 1'b0;
            conflictQ <= 1'b0;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            merr      <= 1'b0;
            iload     <= '0;
            dload     <= '0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            merr <= 1'b0;
            case (state)
                IDLE: begin
                    if (dmemREN || dmemWEN) begin
                        state     <= DACC;
                        addrQ     <= daddr;
                        storeQ    <= dstore;
                        writeQ    <= dmemWEN;
                        conflictQ <= dmemREN && dmemWEN;
                        ramWEN    <= dmemWEN;
                        ramREN    <= !dmemWEN;
                    end else if (iREN) begin
                        state     <= IACC;
                        addrQ     <= iaddr;
                        storeQ    <= dstore;
                        writeQ    <= 1'b0;
                        conflictQ <= 1'b0;
                        ramREN    <= 1'b1;
                        ramWEN    <= 1'b0;
                    end
                end
                DACC, IACC: begin
                    if (accessDone) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        state  <= (state == DACC) ? DRESP : IRESP;
                        dhit   <= (state == DACC);
                        ihit   <= (state == IACC);
                        // ACCESS outranks a simultaneous timeout: the data did arrive.
                        merr   <= (ramstate != ACCESS) || conflictQ;
                        if ((ramstate == ACCESS) && !writeQ) begin
                            if (state == DACC) dload <= ramload;
                            else               iload <= ramload;
                        end
                    end
                end
                DRESP, IRESP: state <= IDLE;
                default:      state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised and directed bench for memory_arbiter against a per-access timing model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam logic [7:0] TMO = 8'd4;
    localparam int T = 4;

    logic      CLK = 1'b0;
    logic      nRST = 1'b0;
    logic      iREN = 1'b0;
    logic      dmemREN = 1'b0;
    logic      dmemWEN = 1'b0;
    word_t     iaddr = '0;
    word_t     daddr = '0;
    word_t     dstore = '0;
    word_t     ramload = '0;
    ramstate_t ramstate = FREE;
    logic      ihit, dhit, merr, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore;

    memory_arbiter #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload), .merr(merr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // Current access: granted at the end of IDLE cycle pG, strobes pG+1..pG+pL, hit in pG+pL+1.
    bit    pValid = 0, pData = 0, pWrite = 0, pErr = 0, pMerr = 0, pLoadUpd = 0;
    int    pG = 0, pL = 0, pD = 0, freeAt = 0;
    word_t pAddr = '0, pStore = '0, pLoad = '0;
    word_t eAddr = '0, eStore = '0, eIload = '0, eDload = '0;

    bit    iOut = 0, dOut = 0, randomMode = 0, holdBusy = 0;
    bit    qI = 0, qD = 0, qDren = 0, qDwen = 0;
    word_t qIaddr = '0, qDaddr = '0, qDstore = '0;
    bit    ovValid = 0, ovErr = 0;
    int    ovD = 0;
    word_t ovLoad = '0;

    int    renHigh, wenHigh, dhitN, ihitN, merrN, lastDhit, lastIhit, firstRen, raised, modelHits;
    word_t wenAddr, wenStore;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic resetStats();
        renHigh = 0; wenHigh = 0; dhitN = 0; ihitN = 0; merrN = 0;
        lastDhit = -1; lastIhit = -1; firstRen = -1; raised = 0; modelHits = 0;
        wenAddr = '0; wenStore = '0;
    endtask

    task automatic setOv(input int d, input bit e, input word_t v);
        ovValid = 1; ovD = d; ovErr = e; ovLoad = v;
    endtask

    task automatic step(input bit doReset);
        bit sExp, hExp, timedOut, conflict;
        int k, r;
        @(negedge CLK);
        cyc++;
        if (pValid && cyc == pG + 1) begin
            eAddr = pAddr;
            eStore = pStore;
        end
        sExp = pValid && (cyc >= pG + 1) && (cyc <= pG + pL);
        hExp = pValid && (cyc == pG + pL + 1);
        if (hExp && pLoadUpd) begin
            if (pData) eDload = pLoad;
            else       eIload = pLoad;
        end

        chk1("ramREN", ramREN, sExp && !pWrite);
        chk1("ramWEN", ramWEN, sExp && pWrite);
        chk32("ramaddr", ramaddr, eAddr);
        chk32("ramstore", ramstore, eStore);
        chk1("ihit", ihit, hExp && !pData);
        chk1("dhit", dhit, hExp && pData);
        chk1("merr", merr, hExp && pMerr);
        chk32("iload", iload, eIload);
        chk32("dload", dload, eDload);
        chk1("hitExclusive", ihit && dhit, 1'b0);
        chk1("strobeExclusive", ramREN && ramWEN, 1'b0);

        if (ramREN) begin
            renHigh++;
            if (firstRen < 0) firstRen = cyc;
        end
        if (ramWEN) begin
            wenHigh++;
            wenAddr = ramaddr;
            wenStore = ramstore;
        end
        if (dhit) begin
            dhitN++;
            lastDhit = cyc;
            if (merr) merrN++;
        end
        if (ihit) begin
            ihitN++;
            lastIhit = cyc;
        end

        if (doReset) begin
            nRST = 0;
            iREN = 0; dmemREN = 0; dmemWEN = 0;
            iOut = 0; dOut = 0; qI = 0; qD = 0;
            #1;
            chk1("asyncRstRen", ramREN, 1'b0);
            chk1("asyncRstWen", ramWEN, 1'b0);
            chk32("asyncRstAddr", ramaddr, 32'h0);
            chk1("asyncRstDhit", dhit, 1'b0);
            pValid = 0; freeAt = 0;
            eAddr = '0; eStore = '0; eIload = '0; eDload = '0;
            ramstate = FREE;
            return;
        end
        if (!nRST) nRST = 1;

        if (hExp) begin
            modelHits++;
            if (pData) begin dmemREN = 0; dmemWEN = 0; dOut = 0; end
            else begin iREN = 0; iOut = 0; end
            pValid = 0;
        end
        if (randomMode && sExp && $urandom_range(0, 15) == 0) begin
            if (pData) begin dmemREN = 0; dmemWEN = 0; end
            else iREN = 0;
        end

        if (qD && !dOut) begin
            dmemREN = qDren; dmemWEN = qDwen; daddr = qDaddr; dstore = qDstore;
            dOut = 1; qD = 0; raised++;
        end
        if (qI && !iOut) begin
            iREN = 1; iaddr = qIaddr; iOut = 1; qI = 0; raised++;
        end
        if (randomMode && !dOut && $urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 9);
            dmemREN = (r < 5) || (r == 9);
            dmemWEN = (r >= 5);
            daddr = $urandom; dstore = $urandom;
            dOut = 1; raised++;
        end
        if (randomMode && !iOut && $urandom_range(0, 3) == 0) begin
            iREN = 1; iaddr = $urandom; iOut = 1; raised++;
        end
        if (!dmemREN && !dmemWEN) begin daddr = $urandom; dstore = $urandom; end
        if (!iREN) iaddr = $urandom;

        if (!pValid && cyc >= freeAt && (dmemREN || dmemWEN || iREN)) begin
            pValid = 1; pG = cyc;
            pData = dmemREN || dmemWEN;
            pWrite = pData && dmemWEN;
            conflict = dmemREN && dmemWEN;
            pAddr = pData ? daddr : iaddr;
            pStore = dstore;
            if (ovValid) begin
                pD = ovD; pErr = ovErr; pLoad = ovLoad; ovValid = 0;
            end else begin
                pD = $urandom_range(0, 5); pErr = ($urandom_range(0, 7) == 0); pLoad = $urandom;
            end
            pL = (pD + 1 < T) ? pD + 1 : T;
            timedOut = (pD + 1 > T);
            pMerr = pErr || timedOut || conflict;
            pLoadUpd = !pWrite && !pErr && !timedOut;
            freeAt = pG + pL + 2;
        end

        if (pValid && cyc >= pG + 1 && cyc <= pG + pL) begin
            k = cyc - pG - 1;
            if (k < pD) ramstate = (holdBusy || $urandom_range(0, 1) == 1) ? BUSY : FREE;
            else        ramstate = pErr ? ERROR : ACCESS;
            ramload = (k == pD) ? pLoad : word_t'($urandom);
        end else begin
            ramstate = ramstate_t'($urandom_range(0, 3));
            ramload = $urandom;
        end
    endtask

    task automatic runUntilIdle(input string name, input int budget);
        int n = 0;
        do begin
            step(0);
            n++;
        end while ((pValid || iOut || dOut || qI || qD) && n < budget);
        checks++;
        if (!(pValid || iOut || dOut || qI || qD)) passes++;
        else $display("FAIL %s: access still outstanding after %0d cycles", name, n);
    endtask

    initial begin
        int n;
        #2;
        chk1("rstRenNoClk", ramREN, 1'b0);
        chk1("rstIhitNoClk", ihit, 1'b0);
        chk32("rstIloadNoClk", iload, 32'h0);
        chk32("rstDloadNoClk", dload, 32'h0);
        chk32("rstAddrNoClk", ramaddr, 32'h0);
        step(1);
        step(1);

        // Instruction fetch, BUSY twice then ACCESS
        resetStats();
        qI = 1; qIaddr = 32'h0000_0040;
        setOv(2, 0, 32'h2401_0005);
        runUntilIdle("ifetchDone", 50);
        chk32("ifetchRenCycles", renHigh, 3);
        chk32("ifetchHitLatency", lastIhit - firstRen, 3);
        chk32("ifetchIload", iload, 32'h2401_0005);
        chk32("ifetchAddr", ramaddr, 32'h0000_0040);
        chk32("ifetchHits", ihitN, 1);

        // Simultaneous write and fetch: write first, one idle cycle, then fetch
        resetStats();
        qI = 1; qIaddr = 32'h200;
        qD = 1; qDren = 0; qDwen = 1; qDaddr = 32'h100; qDstore = 32'hDEAD_BEEF;
        runUntilIdle("prioDone", 60);
        chk32("prioWenAddr", wenAddr, 32'h100);
        chk32("prioWenStore", wenStore, 32'hDEAD_BEEF);
        chk32("prioDhits", dhitN, 1);
        chk32("prioIhits", ihitN, 1);
        chk32("prioGap", firstRen - lastDhit, 2);

        // Known read, then a timed-out read that must leave dload alone
        resetStats();
        qD = 1; qDren = 1; qDwen = 0; qDaddr = 32'h300; qDstore = '0;
        setOv(0, 0, 32'h1234_5678);
        runUntilIdle("readDone", 50);
        chk32("readDload", dload, 32'h1234_5678);
        resetStats();
        qD = 1; qDren = 1; qDwen = 0; qDaddr = 32'h304;
        setOv(20, 0, 32'hFFFF_FFFF);
        holdBusy = 1;
        runUntilIdle("timeoutDone", 50);
        holdBusy = 0;
        chk32("timeoutRenCycles", renHigh, 4);
        chk32("timeoutMerrWithHit", merrN, 1);
        chk32("timeoutDhits", dhitN, 1);
        chk32("timeoutDloadKept", dload, 32'h1234_5678);

        // Read and write both asserted
        resetStats();
        qD = 1; qDren = 1; qDwen = 1; qDaddr = 32'h400; qDstore = 32'h55;
        setOv(1, 0, 32'h0);
        runUntilIdle("bothDone", 50);
        chk32("bothRenCycles", renHigh, 0);
        chk32("bothWenCycles", wenHigh, 2);
        chk32("bothMerr", merrN, 1);

        // Reset in the middle of a data access
        resetStats();
        qD = 1; qDren = 1; qDwen = 0; qDaddr = 32'h500;
        setOv(20, 0, 32'h0);
        holdBusy = 1;
        step(0); step(0); step(0);
        step(1);
        holdBusy = 0;
        for (int i = 0; i < 10; i++) step(0);
        chk32("midRstDhits", dhitN, 0);
        chk32("midRstRenCycles", renHigh, 3);

        // Random traffic
        resetStats();
        randomMode = 1;
        n = 0;
        while (modelHits < 1000 && n < 30000) begin
            step(0);
            n++;
        end
        randomMode = 0;
        checks++;
        if (modelHits >= 1000) passes++;
        else $display("FAIL randBudget: %0d accesses completed, 1000 required", modelHits);
        runUntilIdle("randDrain", 100);
        chk32("randHitsPerRequest", dhitN + ihitN, raised);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8'd255: maximum cycles one RAM access may remain un-ACCESSed before abort.
REQ-002 The block SHALL use one clock (CLK); reset is asynchronous and active-low (nRST).
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 nRST  in  1  async active-low reset.
REQ-005 iREN  in  1  instruction read request, held until ihit.
REQ-006 iaddr  in  32  instruction address (word_t).
REQ-007 dmemREN  in  1  data read request, held until dhit.
REQ-008 dmemWEN  in  1  data write request, held until dhit.
REQ-009 daddr  in  32  data address.
REQ-010 dstore  in  32  data write value.
REQ-011 ihit  out  1  one-cycle pulse: instruction access complete, iload valid.
REQ-012 dhit  out  1  one-cycle pulse: data access complete, dload valid on reads.
REQ-013 iload, dload  out  32 each  registered read data.
REQ-014 merr  out  1  one-cycle pulse coincident with a hit whose access errored or timed out.
REQ-015 ramREN, ramWEN  out  1 each  RAM strobes.
REQ-016 ramaddr, ramstore  out  32 each  RAM address / write data.
REQ-017 ramload  in  32  RAM read data.
REQ-018 ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

Function
REQ-019 FSM states SHALL be IDLE, DACC, IACC, DRESP, IRESP.
REQ-020 IDLE: dmemREN|dmemWEN -> DACC; else iREN -> IACC; else stay; data always wins simultaneous requests.
REQ-021 On leaving IDLE, address, store data and write flag SHALL be latched; RAM outputs driven only from latched values.
REQ-022 dmemREN and dmemWEN both high: treated as write, merr pulsed with dhit.
REQ-023 DACC/IACC: ramREN (read) or ramWEN (write) high, exactly one; stay while ramstate is FREE or BUSY.
REQ-024 ramstate==ACCESS in DACC/IACC -> DRESP/IRESP; on reads ramload captured into dload/iload on that edge.
REQ-025 ramstate==ERROR, or timer reaching TIMEOUT, -> DRESP/IRESP with merr set; load register keeps its prior value.
REQ-026 DRESP/IRESP: dhit/ihit high one cycle, RAM strobes low, -> IDLE unconditionally.
REQ-027 Latency: request seen in IDLE at edge N; strobes high cycles N+1..M (M = ACCESS cycle); hit during cycle M+1; minimum 3 cycles request-to-hit.
REQ-028 Back-to-back: after DRESP, a still-pending iREN is granted from IDLE on the next cycle (one idle cycle between accesses).
REQ-029 Request withdrawn mid-access: access completes; hit still pulses.
REQ-030 Timer: 8-bit, cleared on entering DACC/IACC, +1 per cycle in those states, saturates at TIMEOUT.
REQ-031 ihit and dhit SHALL never be high in the same cycle; ramREN and ramWEN never high together.

Reset
REQ-032 nRST low: state IDLE, timer 0, latches 0, all outputs 0 (iload, dload, ramaddr, ramstore = 32'h0), effective immediately without CLK.
REQ-033 Reset mid-access: strobes drop asynchronously; no hit or merr for the aborted access after release.
REQ-034 First grant possible on the first rising edge after nRST deasserts.

Structure
REQ-035 word_t, ramstate_t and new enum arb_state_t SHALL live in cpu_types_pkg.
REQ-036 TIMEOUT stays a module parameter, not a package constant.
REQ-037 One sub-module, access_timer (clear, enable, limit -> expired), holds the timeout counter.

Verification
REQ-038 iREN=1, iaddr=32'h0000_0040; RAM BUSY 2 cycles then ACCESS with ramload=32'h2401_0005 -> ramREN high 3 cycles, ihit one cycle later, iload=32'h2401_0005.
REQ-039 iREN and dmemWEN together, daddr=32'h100, dstore=32'hDEAD_BEEF -> write served first (ramWEN, ramaddr=32'h100), dhit, one idle cycle, then instruction read, ihit.
REQ-040 dmemREN=1, ramstate held BUSY, TIMEOUT=8'd4 -> abort after 4 cycles, dhit and merr together, dload unchanged.
REQ-041 Access in DACC, nRST pulsed low for one cycle -> strobes low same cycle, state IDLE, no dhit afterwards.
REQ-042 dmemREN and dmemWEN both high -> ramWEN only, dhit with merr.
REQ-043 Random 1000-access run: assert REQ-031 every cycle; every request gets exactly one hit.
